// File: rtl/pp_row_gen_pkg.sv
// Shared types and helpers for the partial-product row generator.
package ppgen_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

    // Lowest set bit of b at or above 'from' among rows 0..w-2; row w-1 is the fallback.
    function automatic int next_set_bit(input logic [MAX_W-1:0] b, input int from, input int w);
        int r;
        r = w - 1;
        for (int k = MAX_W - 2; k >= 0; k--) begin
            if (k >= from && k < w - 1 && b[k]) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_row_gen_if.sv
// Operand-issue and row-output handshake bundle of the row generator.
interface pp_row_gen_if
    import ppgen_pkg::*;
#(
    parameter int W = 8
);
    localparam int IW = idx_w(W);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_signed;
    logic          pp_valid;
    logic          pp_ready;
    logic [W-1:0]  pp_row;
    logic [IW-1:0] pp_idx;
    logic          pp_last;
    logic          pp_corr;
    logic          busy;

    modport master (
        output in_valid, in_a, in_b, in_signed, pp_ready,
        input  in_ready, pp_valid, pp_row, pp_idx, pp_last, pp_corr, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, pp_ready,
        output in_ready, pp_valid, pp_row, pp_idx, pp_last, pp_corr, busy
    );

endinterface

// File: rtl/pp_row_gen_row_logic.sv
// Combinational formation of one gated partial-product row (unsigned or Baugh-Wooley).
module pp_row_logic #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic         b_bit_i,
    input  logic         last_row_i,
    input  logic         signed_i,
    input  logic         valid_i,
    output logic [W-1:0] row_o
);

    logic [W-1:0] and_row;

    assign and_row = a_i & {W{b_bit_i}};

    always_comb begin
        row_o = and_row;
        // Baugh-Wooley: the sign column is inverted on ordinary rows, the magnitude bits on the sign row
        if (signed_i) begin
            if (last_row_i) begin
                row_o        = ~and_row;
                row_o[W-1]   = and_row[W-1];
            end else begin
                row_o[W-1]   = ~and_row[W-1];
            end
        end
        if (!valid_i) row_o = '0;
    end

endmodule

// File: rtl/pp_row_gen.sv
// Latches a W x W operand pair and streams one gated partial-product row per handshake.
module pp_row_gen
    import ppgen_pkg::*;
#(
    parameter int W         = 8,
    parameter bit SKIP_ZERO = 1'b0
) (
    input logic        clk,
    input logic        rst,
    pp_row_gen_if.slave pp_if
);

    localparam int            IW       = idx_w(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sgn_q, sgn_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          corr_q, corr_d;
    logic          vld;
    logic          last_row;

    function automatic logic [IW-1:0] skip_from(input logic [W-1:0] b, input int from);
        return IW'(next_set_bit(MAX_W'(b), from, W));
    endfunction

    assign vld      = (state_q == EMIT);
    assign last_row = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        corr_d  = corr_q;
        unique case (state_q)
            IDLE: begin
                if (pp_if.in_valid) begin
                    a_d     = pp_if.in_a;
                    b_d     = pp_if.in_b;
                    sgn_d   = pp_if.in_signed;
                    corr_d  = pp_if.in_signed;
                    state_d = EMIT;
                    idx_d   = (SKIP_ZERO && !pp_if.in_signed) ? skip_from(pp_if.in_b, 0) : '0;
                end
            end
            EMIT: begin
                if (pp_if.pp_ready) begin
                    corr_d = 1'b0;
                    if (last_row) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else if (SKIP_ZERO && !sgn_q) begin
                        idx_d = skip_from(b_q, int'(idx_q) + 1);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            corr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            corr_q  <= corr_d;
        end
    end

    // Operand registers carry no reset; every row they feed is gated by the FSM state.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sgn_q <= sgn_d;
    end

    pp_row_logic #(.W(W)) u_row (
        .a_i        (a_q),
        .b_bit_i    (b_q[idx_q]),
        .last_row_i (last_row),
        .signed_i   (sgn_q),
        .valid_i    (vld),
        .row_o      (pp_if.pp_row)
    );

    assign pp_if.in_ready = (state_q == IDLE);
    assign pp_if.busy     = vld;
    assign pp_if.pp_valid = vld;
    assign pp_if.pp_idx   = idx_q;
    assign pp_if.pp_last  = vld && last_row;
    assign pp_if.pp_corr  = vld && corr_q;

endmodule
